// File: rtl/p_s_pkg.sv
// Shared definitions for the parallel-to-serial bit-link transmitter.
package p_s_pkg;

   localparam int unsigned P_S_DATA_W = 8;

   function automatic int unsigned bit_cnt_w(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int unsigned P_S_BIT_CNT_W = bit_cnt_w(P_S_DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } p_s_state_e;

endpackage

// File: rtl/p_s_shift_reg.sv
// Parallel-load, shift-left register; msb is the bit currently on the wire.
module p_s_shift_reg
   import p_s_pkg::*;
#(
   parameter int unsigned DATA_W = P_S_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld,
   input  logic              shift,
   input  logic [DATA_W-1:0] d,
   output logic              msb
);

   logic [DATA_W-1:0] r_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (ld) begin
         r_sr <= d;
      end else if (shift) begin
         r_sr <= {r_sr[DATA_W-2:0], 1'b0};
      end
   end

   assign msb = r_sr[DATA_W-1];

endmodule

// File: rtl/p_s_tx.sv
// Parallel-to-serial transmitter: one-word holding register, MSB-first shift,
// Dbit_ena framing with a fixed GAP-cycle low period between frames.
module p_s_tx
   import p_s_pkg::*;
#(
   parameter int unsigned DATA_W = P_S_DATA_W,
   parameter int unsigned GAP    = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              Dbit_out,
   output logic              Dbit_ena,
   output logic              done
);

   localparam int unsigned      CNT_W    = bit_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [3:0]       GAP_LOAD = 4'(GAP - 1);

   p_s_state_e        r_state, w_state_nxt;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_valid;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [3:0]        r_gap_cnt;
   logic              r_ena;
   logic              r_done;
   logic              w_accept, w_start, w_shift, w_end, w_msb;

   // A transfer needs hold_valid=1, so it can never coincide with an accept.
   assign w_accept = load & ~r_hold_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_hold_valid) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_end       = 1'b1;
               w_state_nxt = ST_GAP;
            end else begin
               w_shift = 1'b1;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               if (r_hold_valid) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_SHIFT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_ena        <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_end;
         if (w_accept) begin
            r_hold       <= data_in;
            r_hold_valid <= 1'b1;
         end else if (w_start) begin
            r_hold_valid <= 1'b0;
         end
         if (w_start) begin
            r_ena     <= 1'b1;
            r_bit_cnt <= '0;
         end else if (w_end) begin
            r_ena <= 1'b0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_end) begin
            r_gap_cnt <= GAP_LOAD;
         end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
         end
      end
   end

   p_s_shift_reg #(.DATA_W(DATA_W)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (w_start),
      .shift (w_shift),
      .d     (r_hold),
      .msb   (w_msb)
   );

   // Gating with the enable clears the line asynchronously and between frames.
   assign Dbit_out = r_ena & w_msb;
   assign Dbit_ena = r_ena;
   assign ready    = ~r_hold_valid;
   assign done     = r_done;

endmodule

// File: tb/tb_p_s_tx.sv
// Bench for p_s_tx: negedge receiver models feed scoreboards of expected words.
module tb_p_s_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = '0, data3 = '0;
   logic       load = 1'b0, load3 = 1'b0;
   logic       ready, dout, dena, done;
   logic       ready3, dout3, dena3, done3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q[$];
   logic [7:0] q3[$];
   logic [7:0] rx_word = '0, rx3_word = '0;
   int         rx_cnt = 0, rx3_cnt = 0;

   always #5 clk = ~clk;

   p_s_tx #(.DATA_W(8), .GAP(1)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
      .ready(ready), .Dbit_out(dout), .Dbit_ena(dena), .done(done)
   );

   p_s_tx #(.DATA_W(8), .GAP(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .data_in(data3), .load(load3),
      .ready(ready3), .Dbit_out(dout3), .Dbit_ena(dena3), .done(done3)
   );

   always @(negedge clk) begin
      logic [7:0] e_word;
      if (!rst_n) begin
         rx_cnt = 0;
      end else if (dena) begin
         rx_word = {rx_word[6:0], dout};
         rx_cnt++;
         if (rx_cnt == 8) begin
            rx_cnt = 0;
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rx_extra: got %h, expected no frame", rx_word);
            end else begin
               e_word = q.pop_front();
               if (rx_word !== e_word) begin
                  n_fail++;
                  $display("FAIL rx_word: got %h, expected %h", rx_word, e_word);
               end
            end
         end
      end else if (rx_cnt != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_partial: got %0d bits, expected 0 or 8", rx_cnt);
         rx_cnt = 0;
      end
   end

   always @(negedge clk) begin
      logic [7:0] e_word;
      if (!rst_n) begin
         rx3_cnt = 0;
      end else if (dena3) begin
         rx3_word = {rx3_word[6:0], dout3};
         rx3_cnt++;
         if (rx3_cnt == 8) begin
            rx3_cnt = 0;
            n_tests++;
            if (q3.size() == 0) begin
               n_fail++;
               $display("FAIL rx3_extra: got %h, expected no frame", rx3_word);
            end else begin
               e_word = q3.pop_front();
               if (rx3_word !== e_word) begin
                  n_fail++;
                  $display("FAIL rx3_word: got %h, expected %h", rx3_word, e_word);
               end
            end
         end
      end else if (rx3_cnt != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx3_partial: got %0d bits, expected 0 or 8", rx3_cnt);
         rx3_cnt = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({dena, dout, done, ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_outs: got %b, expected 0001", {dena, dout, done, ready});
      end
      n_tests++;
      if ({dena3, dout3, done3, ready3} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_outs3: got %b, expected 0001", {dena3, dout3, done3, ready3});
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 50; i++) begin
         cyc();
         n_tests++;
         if ({dena, dout, done, ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL idle_outs cyc %0d: got %b, expected 0001", i, {dena, dout, done, ready});
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] w;
      w = 8'hA5;
      data_in = w;
      load = 1'b1;
      q.push_back(w);
      cyc();
      load = 1'b0;
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ready: got %b, expected 0", ready);
      end
      for (int i = 1; i <= 8; i++) begin
         cyc();
         n_tests++;
         if ({dena, dout, done} !== {1'b1, w[8-i], 1'b0}) begin
            n_fail++;
            $display("FAIL single_bit %0d: got ena/out/done %b, expected %b", i, {dena, dout, done}, {1'b1, w[8-i], 1'b0});
         end
      end
      cyc();
      n_tests++;
      if ({dena, dout, done} !== 3'b001) begin
         n_fail++;
         $display("FAIL single_end: got ena/out/done %b, expected 001", {dena, dout, done});
      end
      cyc();
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done_pulse: got %b, expected 0", done);
      end
      cyc();
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL single_drain: got %0d words pending, expected 0", q.size());
      end
   endtask

   // Covers the dropped load too: 8'h77 arrives while the holding register is full.
   task automatic test_back_to_back();
      logic e_ena, e_done, e_rdy;
      for (int k = 0; k <= 20; k++) begin
         load = 1'b0;
         if (k == 0) begin
            data_in = 8'h3C; load = 1'b1; q.push_back(8'h3C);
         end else if (k == 2) begin
            data_in = 8'hC3; load = 1'b1; q.push_back(8'hC3);
         end else if (k == 4) begin
            data_in = 8'h77; load = 1'b1;
         end
         cyc();
         e_ena  = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
         e_done = (k == 9) || (k == 18);
         e_rdy  = (k == 1) || (k >= 10);
         n_tests++;
         if ({dena, done, ready} !== {e_ena, e_done, e_rdy}) begin
            n_fail++;
            $display("FAIL b2b cyc %0d: got ena/done/ready %b, expected %b", k, {dena, done, ready}, {e_ena, e_done, e_rdy});
         end
      end
      load = 1'b0;
      cyc();
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got %0d words pending, expected 0", q.size());
      end
   endtask

   task automatic test_reset_mid();
      data_in = 8'hF0;
      load = 1'b1;
      q.push_back(8'hF0);
      cyc();
      load = 1'b0;
      cyc();
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      n_tests++;
      if ({dena, dout, done, ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL midrst_async: got %b, expected 0001", {dena, dout, done, ready});
      end
      cyc();
      n_tests++;
      if ({dena, dout, done, ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL midrst_held: got %b, expected 0001", {dena, dout, done, ready});
      end
      rst_n = 1'b1;
      cyc();
      data_in = 8'hFF;
      load = 1'b1;
      q.push_back(8'hFF);
      cyc();
      load = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         n_tests++;
         if ({dena, dout} !== 2'b11) begin
            n_fail++;
            $display("FAIL midrst_bit %0d: got ena/out %b, expected 11", i, {dena, dout});
         end
      end
      cyc();
      n_tests++;
      if ({dena, done} !== 2'b01) begin
         n_fail++;
         $display("FAIL midrst_end: got ena/done %b, expected 01", {dena, done});
      end
      cyc();
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_drain: got %0d words pending, expected 0", q.size());
      end
   endtask

   task automatic test_gap3();
      logic e_ena, e_done, e_rdy;
      for (int k = 0; k <= 36; k++) begin
         load3 = 1'b0;
         if (k == 0) begin
            data3 = 8'h81; load3 = 1'b1; q3.push_back(8'h81);
         end else if (k == 2) begin
            data3 = 8'h5A; load3 = 1'b1; q3.push_back(8'h5A);
         end else if (k == 13) begin
            data3 = 8'hE7; load3 = 1'b1; q3.push_back(8'hE7);
         end
         cyc();
         e_ena  = (k >= 1 && k <= 8) || (k >= 12 && k <= 19) || (k >= 23 && k <= 30);
         e_done = (k == 9) || (k == 20) || (k == 31);
         e_rdy  = (k == 1) || (k == 12) || (k >= 23);
         n_tests++;
         if ({dena3, done3, ready3} !== {e_ena, e_done, e_rdy}) begin
            n_fail++;
            $display("FAIL gap3 cyc %0d: got ena/done/ready %b, expected %b", k, {dena3, done3, ready3}, {e_ena, e_done, e_rdy});
         end
      end
      load3 = 1'b0;
      n_tests++;
      if (q3.size() != 0) begin
         n_fail++;
         $display("FAIL gap3_drain: got %0d words pending, expected 0", q3.size());
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_gap3();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
